// File: rtl/ir_queue.sv
// Instruction register with a DEPTH-entry prefetch queue for the SAP core.
// The head word is presented pre-split into opcode and an extended operand.
module ir_queue #(
  parameter int DATA_W   = 16,
  parameter int OPC_W    = 4,
  parameter int DEPTH    = 2,
  parameter int SIGN_EXT = 0,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ir_write,
  input  logic [DATA_W-1:0] bus,
  input  logic              ir_next,
  input  logic              flush,
  output logic [DATA_W-1:0] ir_out,
  output logic [OPC_W-1:0]  opcode,
  output logic [DATA_W-1:0] operand,
  output logic              ir_valid,
  output logic              ir_full,
  output logic [CNT_W-1:0]  ir_count,
  output logic              ovf_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OPR_W = DATA_W - OPC_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              valid;
  logic              full;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head;
  logic [OPC_W-1:0]  ext;

  assign valid = (count != '0);
  assign full  = (count == CNT_W'(DEPTH));
  // A pop frees a slot on the same edge, so a full queue can still accept a word.
  assign push  = ir_write & (~full | ir_next);
  assign pop   = ir_next & valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (ir_write && full && !ir_next) ovf_err <= 1'b1;
    end
  end

  // Stale storage stays in place after pop/flush; gating here hides it when empty.
  assign head     = valid ? mem[rd_ptr] : '0;
  assign ext      = (SIGN_EXT != 0) ? {OPC_W{head[OPR_W-1]}} : '0;
  assign ir_out   = head;
  assign opcode   = head[DATA_W-1 -: OPC_W];
  assign operand  = {ext, head[OPR_W-1:0]};
  assign ir_valid = valid;
  assign ir_full  = full;
  assign ir_count = count;

endmodule

// File: tb/tb_ir_queue.sv
// Self-checking bench for ir_queue: a scoreboard queue tracks the expected contents,
// with a second sign-extending instance sharing the same stimulus.
module tb_ir_queue;

  localparam int DATA_W = 16;
  localparam int OPC_W  = 4;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              ir_write;
  logic [DATA_W-1:0] bus;
  logic              ir_next;
  logic              flush;
  logic [DATA_W-1:0] ir_out,  sx_ir_out;
  logic [OPC_W-1:0]  opcode,  sx_opcode;
  logic [DATA_W-1:0] operand, sx_operand;
  logic              ir_valid, sx_ir_valid;
  logic              ir_full,  sx_ir_full;
  logic [CNT_W-1:0]  ir_count, sx_ir_count;
  logic              ovf_err,  sx_ovf_err;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] sb[$];
  logic              ovf_m;
  logic [DATA_W-1:0] exp_head;

  ir_queue #(.DATA_W(DATA_W), .OPC_W(OPC_W), .DEPTH(DEPTH), .SIGN_EXT(0)) dut (
    .clk(clk), .rst(rst), .ir_write(ir_write), .bus(bus), .ir_next(ir_next), .flush(flush),
    .ir_out(ir_out), .opcode(opcode), .operand(operand), .ir_valid(ir_valid),
    .ir_full(ir_full), .ir_count(ir_count), .ovf_err(ovf_err)
  );

  ir_queue #(.DATA_W(DATA_W), .OPC_W(OPC_W), .DEPTH(DEPTH), .SIGN_EXT(1)) u_sx (
    .clk(clk), .rst(rst), .ir_write(ir_write), .bus(bus), .ir_next(ir_next), .flush(flush),
    .ir_out(sx_ir_out), .opcode(sx_opcode), .operand(sx_operand), .ir_valid(sx_ir_valid),
    .ir_full(sx_ir_full), .ir_count(sx_ir_count), .ovf_err(sx_ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one edge and advances the reference queue with the same push/pop priority.
  task automatic step(input logic w, input logic [DATA_W-1:0] d, input logic n, input logic f);
    logic m_full, m_push, m_pop;
    ir_write = w; bus = d; ir_next = n; flush = f;
    @(posedge clk);
    if (f) begin
      sb.delete();
    end else begin
      m_full = (sb.size() == DEPTH);
      m_push = w && (!m_full || n);
      m_pop  = n && (sb.size() > 0);
      if (w && m_full && !n) ovf_m = 1'b1;
      if (m_pop)  void'(sb.pop_front());
      if (m_push) sb.push_back(d);
    end
    #1;
    ir_write = 1'b0; ir_next = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; ovf_m = 1'b0; sb.delete();
    for (int i = 0; i < 4; i++) begin
      ir_write = 1'($urandom); bus = 16'($urandom); ir_next = 1'($urandom); flush = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({ir_out, opcode, operand, ir_valid, ir_full, ir_count, ovf_err} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_hold got out=%h opc=%h opr=%h v=%b f=%b c=%0d ovf=%b want all 0",
                 ir_out, opcode, operand, ir_valid, ir_full, ir_count, ovf_err);
      end
    end
    ir_write = 1'b0; ir_next = 1'b0; flush = 1'b0; bus = '0;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({ir_out, opcode, operand, ir_valid, ir_full, ir_count, ovf_err} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_idle got out=%h v=%b c=%0d ovf=%b want all 0",
                 ir_out, ir_valid, ir_count, ovf_err);
      end
    end
  endtask

  task automatic test_push();
    step(1'b1, 16'h3A05, 1'b0, 1'b0);
    exp_head = sb[0];
    checks++;
    if (ir_out !== exp_head) begin errors++; $display("[TB] FAIL push_ir_out got %h want %h", ir_out, exp_head); end
    checks++;
    if (opcode !== 4'h3) begin errors++; $display("[TB] FAIL push_opcode got %h want 3", opcode); end
    checks++;
    if (operand !== 16'h0A05) begin errors++; $display("[TB] FAIL push_operand got %h want 0a05", operand); end
    checks++;
    if (sx_operand !== 16'hFA05) begin errors++; $display("[TB] FAIL push_sx_operand got %h want fa05", sx_operand); end
    checks++;
    if (ir_valid !== 1'b1 || ir_count !== CNT_W'(sb.size())) begin
      errors++; $display("[TB] FAIL push_valid_count got v=%b c=%0d want v=1 c=%0d", ir_valid, ir_count, sb.size());
    end
    step(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (ir_valid !== 1'b0 || ir_out !== '0) begin
      errors++; $display("[TB] FAIL pop_to_empty got v=%b out=%h want v=0 out=0", ir_valid, ir_out);
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 16'h1001, 1'b0, 1'b0);
    step(1'b1, 16'h2002, 1'b0, 1'b0);
    step(1'b1, 16'h3003, 1'b0, 1'b0);
    checks++;
    if (ir_full !== 1'b1 || ovf_err !== ovf_m) begin
      errors++; $display("[TB] FAIL ovf_flags got full=%b ovf=%b want full=1 ovf=%b", ir_full, ovf_err, ovf_m);
    end
    exp_head = sb[0];
    checks++;
    if (ir_out !== exp_head || ir_count !== CNT_W'(sb.size())) begin
      errors++; $display("[TB] FAIL ovf_head got %h c=%0d want %h c=%0d", ir_out, ir_count, exp_head, sb.size());
    end
    step(1'b1, 16'h4004, 1'b1, 1'b0);
    exp_head = sb[0];
    checks++;
    if (ir_out !== exp_head || ir_count !== CNT_W'(sb.size()) || ir_full !== 1'b1) begin
      errors++; $display("[TB] FAIL full_push_pop got %h c=%0d full=%b want %h c=%0d full=1",
                         ir_out, ir_count, ir_full, exp_head, sb.size());
    end
    step(1'b0, '0, 1'b1, 1'b0);
    exp_head = sb[0];
    checks++;
    if (ir_out !== exp_head || ir_count !== CNT_W'(sb.size())) begin
      errors++; $display("[TB] FAIL slot_reuse got %h c=%0d want %h c=%0d", ir_out, ir_count, exp_head, sb.size());
    end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_sign_ext();
    step(1'b1, 16'h5800, 1'b0, 1'b0);
    checks++;
    if (operand !== 16'h0800) begin errors++; $display("[TB] FAIL zext_operand got %h want 0800", operand); end
    checks++;
    if (sx_operand !== 16'hF800) begin errors++; $display("[TB] FAIL sext_operand got %h want f800", sx_operand); end
    checks++;
    if (sx_opcode !== 4'h5) begin errors++; $display("[TB] FAIL sext_opcode got %h want 5", sx_opcode); end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    step(1'b1, 16'h1111, 1'b0, 1'b0);
    step(1'b1, 16'h2222, 1'b0, 1'b0);
    step(1'b1, 16'h7777, 1'b0, 1'b1);
    checks++;
    if (ir_valid !== 1'b0 || ir_count !== '0 || ir_out !== '0) begin
      errors++; $display("[TB] FAIL flush_empty got v=%b c=%0d out=%h want v=0 c=0 out=0", ir_valid, ir_count, ir_out);
    end
    checks++;
    if (ovf_err !== ovf_m) begin errors++; $display("[TB] FAIL flush_ovf_held got %b want %b", ovf_err, ovf_m); end
    step(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (ir_out === 16'h7777 || ir_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL flush_dropped_word got out=%h v=%b want out=0 v=0", ir_out, ir_valid);
    end
  endtask

  task automatic test_empty_edges();
    step(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (ir_count !== '0 || ir_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL underflow got c=%0d v=%b want c=0 v=0", ir_count, ir_valid);
    end
    step(1'b1, 16'hAAAA, 1'b1, 1'b0);
    exp_head = sb[0];
    checks++;
    if (ir_count !== CNT_W'(sb.size()) || ir_out !== exp_head) begin
      errors++; $display("[TB] FAIL empty_push_next got c=%0d out=%h want c=%0d out=%h", ir_count, ir_out, sb.size(), exp_head);
    end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'(i), 1'b0, 1'b0);
      exp_head = sb[0];
      checks++;
      if (ir_out !== exp_head || ir_count > CNT_W'(1)) begin
        errors++; $display("[TB] FAIL wrap_head_%0d got %h c=%0d want %h c<=1", i, ir_out, ir_count, exp_head);
      end
      if (i == 5) begin
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({ir_out, operand, ir_valid, ir_count, ovf_err, sx_ir_out} !== '0) begin
          errors++; $display("[TB] FAIL async_reset got out=%h v=%b c=%0d ovf=%b want all 0",
                             ir_out, ir_valid, ir_count, ovf_err);
        end
        sb.delete(); ovf_m = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end else begin
        step(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (ir_count !== CNT_W'(sb.size()) || ir_valid !== 1'b0) begin
          errors++; $display("[TB] FAIL wrap_pop_%0d got c=%0d v=%b want c=0 v=0", i, ir_count, ir_valid);
        end
      end
    end
  endtask

  initial begin
    ir_write = 1'b0; bus = '0; ir_next = 1'b0; flush = 1'b0;
    $display("[TB] starting ir_queue bench");
    test_reset();
    test_push();
    test_overflow();
    test_sign_ext();
    test_flush();
    test_empty_edges();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
